// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog supervisor: FSM state encodings,
// configuration register select codes and the reset defaults of the
// timer period registers.
package wdt_pkg;

    typedef enum logic [1:0] {
        ST_CONFIG   = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FAILSAFE = 2'd2,
        ST_HWRST    = 2'd3
    } wdt_state_e;

    localparam logic [1:0] SEL_WAIT   = 2'd0;
    localparam logic [1:0] SEL_RST    = 2'd1;
    localparam logic [1:0] SEL_MASK   = 2'd2;
    localparam logic [1:0] SEL_MINWIN = 2'd3;

    localparam int unsigned DEF_WAIT_PERIOD = 1000;
    localparam int unsigned DEF_RST_PERIOD  = 100;

endpackage

// File: rtl/wdt_supervisor_if.sv
// Signal bundle between the supervisor and its environment: config bus,
// lock request, task check-ins, the watchdog link and status outputs.
//   master : drives i_* (software / testbench / timer side), samples o_*
//   slave  : the supervisor itself
interface wdt_supervisor_if #(
    parameter int N_TASKS = 4,
    parameter int W       = 32,
    parameter int CNT_W   = 16
);
    logic               i_cfg_we;
    logic [1:0]         i_cfg_sel;
    logic [W-1:0]       i_cfg_data;
    logic               i_lock;
    logic [N_TASKS-1:0] i_checkin;
    logic               i_fail_safe;
    logic               i_hardware_rst;

    logic               o_clrwdt;
    logic [W-1:0]       o_wait_period;
    logic [W-1:0]       o_rst_period;
    logic               o_locked;
    logic [1:0]         o_state;
    logic [N_TASKS-1:0] o_missing;
    logic               o_early;
    logic [CNT_W-1:0]   o_rst_count;

    modport master (
        output i_cfg_we, i_cfg_sel, i_cfg_data, i_lock, i_checkin,
               i_fail_safe, i_hardware_rst,
        input  o_clrwdt, o_wait_period, o_rst_period, o_locked, o_state,
               o_missing, o_early, o_rst_count
    );

    modport slave (
        input  i_cfg_we, i_cfg_sel, i_cfg_data, i_lock, i_checkin,
               i_fail_safe, i_hardware_rst,
        output o_clrwdt, o_wait_period, o_rst_period, o_locked, o_state,
               o_missing, o_early, o_rst_count
    );
endinterface

// File: rtl/wdt_checkin_collector.sv
// Per-window check-in bookkeeping: the seen vector, the window counter,
// early check-in detection and the all-present compare.
//   i_en        : window is live (ARMED and no fail-safe this cycle)
//   i_restart   : start a fresh window (seen and counter cleared)
//   i_mask      : enabled tasks
//   i_min_window: earliest counter value at which check-ins are accepted
//   i_checkin   : one-cycle check-in pulses
//   o_fire      : every enabled task is in and the window is open
//   o_early_hit : an enabled task checked in before the window opened
//   o_seen      : registered seen vector
module wdt_checkin_collector #(
    parameter int N_TASKS = 4,
    parameter int W       = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_restart,
    input  logic [N_TASKS-1:0] i_mask,
    input  logic [W-1:0]       i_min_window,
    input  logic [N_TASKS-1:0] i_checkin,
    output logic               o_fire,
    output logic               o_early_hit,
    output logic [N_TASKS-1:0] o_seen
);
    logic [N_TASKS-1:0] seen_q;
    logic [W-1:0]       win_cnt_q;
    logic [N_TASKS-1:0] seen_base;
    logic [N_TASKS-1:0] ci_masked;
    logic [W-1:0]       win_base;
    logic               ci_in_window;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // On a fire cycle the current check-ins already belong to the new window,
    // so they are judged against a counter of zero and an empty seen vector.
    always_comb begin
        o_fire       = i_en && ((seen_q & i_mask) == i_mask) && (win_cnt_q >= i_min_window);
        seen_base    = o_fire ? '0 : seen_q;
        win_base     = o_fire ? '0 : win_cnt_q;
        ci_masked    = i_checkin & i_mask;
        ci_in_window = (win_base >= i_min_window);
        o_early_hit  = i_en && (|ci_masked) && !ci_in_window;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            seen_q    <= '0;
            win_cnt_q <= '0;
        end else if (i_restart) begin
            seen_q    <= '0;
            win_cnt_q <= '0;
        end else if (i_en) begin
            seen_q    <= seen_base | (ci_in_window ? ci_masked : '0);
            win_cnt_q <= o_fire ? '0 : sat_inc(win_cnt_q);
        end
    end

    assign o_seen = seen_q;

endmodule

// File: rtl/wdt_supervisor.sv
// Supervisor for one watchdog timer: lockable period/mask/window registers,
// a CONFIG/ARMED/FAILSAFE/HWRST sequencer, the clear pulse to the timer,
// missing-task capture and a saturating hardware-reset episode counter.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : config bus, lock, check-ins, timer link and status
module wdt_supervisor
    import wdt_pkg::*;
#(
    parameter int N_TASKS = 4,
    parameter int W       = 32,
    parameter int CNT_W   = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    wdt_supervisor_if.slave bus
);
    wdt_state_e         state_q, state_d;
    logic [W-1:0]       wait_q, rstp_q, minwin_q;
    logic [N_TASKS-1:0] mask_q, mask_eff, missing_q, seen;
    logic               clr_q, clr_d, locked_q, early_q;
    logic [CNT_W-1:0]   rst_cnt_q;
    logic               cfg_wr, col_en, col_restart, col_fire, col_early_hit;
    logic               cnt_inc, miss_ld;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign cfg_wr   = (state_q == ST_CONFIG) && bus.i_cfg_we;
    // A write and a lock in the same cycle: the lock sees the mask being written.
    assign mask_eff = (cfg_wr && (bus.i_cfg_sel == SEL_MASK)) ?
                      bus.i_cfg_data[N_TASKS-1:0] : mask_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_q   <= W'(DEF_WAIT_PERIOD);
            rstp_q   <= W'(DEF_RST_PERIOD);
            mask_q   <= '1;
            minwin_q <= '0;
        end else if (cfg_wr) begin
            case (bus.i_cfg_sel)
                SEL_WAIT: wait_q   <= bus.i_cfg_data;
                SEL_RST:  rstp_q   <= bus.i_cfg_data;
                SEL_MASK: mask_q   <= bus.i_cfg_data[N_TASKS-1:0];
                default:  minwin_q <= bus.i_cfg_data;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_CONFIG;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CONFIG:   if (bus.i_lock && (mask_eff != '0)) state_d = ST_ARMED;
            ST_ARMED:    if (bus.i_fail_safe) state_d = ST_FAILSAFE;
            ST_FAILSAFE: begin
                if (bus.i_hardware_rst)    state_d = ST_HWRST;
                else if (!bus.i_fail_safe) state_d = ST_ARMED;
            end
            ST_HWRST:    if (!bus.i_hardware_rst) state_d = ST_ARMED;
            default:     state_d = ST_CONFIG;
        endcase
    end

    // Fail-safe outranks a same-cycle clear: the collector is frozen that cycle.
    always_comb begin
        col_en      = (state_q == ST_ARMED) && !bus.i_fail_safe;
        col_restart = (state_d == ST_ARMED) && (state_q != ST_ARMED);
        clr_d       = (state_d == ST_CONFIG) || col_fire;
        cnt_inc     = (state_q == ST_HWRST) && !bus.i_hardware_rst;
        miss_ld     = (state_q == ST_ARMED) && bus.i_fail_safe;
    end

    wdt_checkin_collector #(.N_TASKS(N_TASKS), .W(W)) u_collector (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (col_en),
        .i_restart    (col_restart),
        .i_mask       (mask_q),
        .i_min_window (minwin_q),
        .i_checkin    (bus.i_checkin),
        .o_fire       (col_fire),
        .o_early_hit  (col_early_hit),
        .o_seen       (seen)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            clr_q     <= 1'b1;
            locked_q  <= 1'b0;
            early_q   <= 1'b0;
            missing_q <= '0;
            rst_cnt_q <= '0;
        end else begin
            clr_q    <= clr_d;
            locked_q <= locked_q || ((state_q == ST_CONFIG) && (state_d == ST_ARMED));
            early_q  <= early_q || col_early_hit;
            if (miss_ld) missing_q <= mask_q & ~seen;
            if (cnt_inc) rst_cnt_q <= sat_inc_cnt(rst_cnt_q);
        end
    end

    assign bus.o_clrwdt      = clr_q;
    assign bus.o_wait_period = wait_q;
    assign bus.o_rst_period  = rstp_q;
    assign bus.o_locked      = locked_q;
    assign bus.o_state       = state_q;
    assign bus.o_missing     = missing_q;
    assign bus.o_early       = early_q;
    assign bus.o_rst_count   = rst_cnt_q;

endmodule

// File: tb/tb_wdt_supervisor.sv
// Bench for wdt_supervisor: directed and random stimulus, a behavioural
// model stepped once per clock that queues the expected outputs, and a
// negedge monitor that pops and compares them.
module tb_wdt_supervisor;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int CW = 16;
    localparam longint WIN_MAX = (longint'(1) << W) - 1;
    localparam int     CNT_MAX = (1 << CW) - 1;

    typedef struct {
        bit         clr;
        longint     wp;
        longint     rp;
        bit         locked;
        int         st;
        bit [N-1:0] miss;
        bit         early;
        int         cnt;
    } exp_t;

    logic clk;
    logic rst;
    wdt_supervisor_if #(.N_TASKS(N), .W(W), .CNT_W(CW)) bus();

    wdt_supervisor #(.N_TASKS(N), .W(W), .CNT_W(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete, got no summary, required one");
        $fatal(1, "timeout");
    end

    // stimulus copies (the model reads these, never the DUT)
    logic         t_rst, t_we, t_lock, t_fs, t_hr;
    logic [1:0]   t_sel;
    logic [W-1:0] t_data;
    logic [N-1:0] t_ci;

    // model state
    int     m_state;
    longint m_wait, m_rstp, m_minw, m_win;
    bit     m_mask[N], m_seen[N], m_miss[N];
    bit     m_clr, m_locked, m_early;
    int     m_cnt;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   stim_done = 0;
    int   ep = 0, hr_len = 0;

    function automatic void model_reset();
        m_state = 0; m_wait = 1000; m_rstp = 100; m_minw = 0; m_win = 0;
        for (int i = 0; i < N; i++) begin m_mask[i] = 1; m_seen[i] = 0; m_miss[i] = 0; end
        m_clr = 1; m_locked = 0; m_early = 0; m_cnt = 0;
    endfunction

    function automatic void new_window();
        for (int i = 0; i < N; i++) m_seen[i] = 0;
        m_win = 0;
    endfunction

    function automatic void model_step();
        bit     any_mask, done;
        longint win_now;
        if (t_rst) begin model_reset(); return; end
        case (m_state)
            0: begin
                if (t_we) begin
                    if (t_sel == 0)      m_wait = t_data;
                    else if (t_sel == 1) m_rstp = t_data;
                    else if (t_sel == 2) for (int i = 0; i < N; i++) m_mask[i] = t_data[i];
                    else                 m_minw = t_data;
                end
                any_mask = 0;
                for (int i = 0; i < N; i++) if (m_mask[i]) any_mask = 1;
                if (t_lock && any_mask) begin m_state = 1; m_locked = 1; new_window(); end
                m_clr = (m_state == 0);
            end
            1: begin
                if (t_fs) begin
                    for (int i = 0; i < N; i++) m_miss[i] = m_mask[i] && !m_seen[i];
                    m_state = 2;
                    m_clr = 0;
                end else begin
                    done = (m_win >= m_minw);
                    for (int i = 0; i < N; i++) if (m_mask[i] && !m_seen[i]) done = 0;
                    m_clr = done;
                    win_now = done ? 0 : m_win;
                    if (done) for (int i = 0; i < N; i++) m_seen[i] = 0;
                    for (int i = 0; i < N; i++)
                        if (t_ci[i] && m_mask[i]) begin
                            if (win_now >= m_minw) m_seen[i] = 1;
                            else                   m_early = 1;
                        end
                    m_win = done ? 0 : ((m_win == WIN_MAX) ? m_win : m_win + 1);
                end
            end
            2: begin
                m_clr = 0;
                if (t_hr) m_state = 3;
                else if (!t_fs) begin m_state = 1; new_window(); end
            end
            default: begin
                m_clr = 0;
                if (!t_hr) begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_state = 1;
                    new_window();
                end
            end
        endcase
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.clr = m_clr; e.wp = m_wait; e.rp = m_rstp; e.locked = m_locked;
        e.st = m_state; e.early = m_early; e.cnt = m_cnt;
        for (int i = 0; i < N; i++) e.miss[i] = m_miss[i];
        return e;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("clrwdt",      64'(bus.o_clrwdt),      64'(e.clr));
            cmp("wait_period", 64'(bus.o_wait_period), 64'(e.wp));
            cmp("rst_period",  64'(bus.o_rst_period),  64'(e.rp));
            cmp("locked",      64'(bus.o_locked),      64'(e.locked));
            cmp("state",       64'(bus.o_state),       64'(e.st));
            cmp("missing",     64'(bus.o_missing),     64'(e.miss));
            cmp("early",       64'(bus.o_early),       64'(e.early));
            cmp("rst_count",   64'(bus.o_rst_count),   64'(e.cnt));
        end
        if (stim_done && q.size() == 0) begin
            $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
            $finish;
        end
    end

    task automatic drive();
        rst                = t_rst;
        bus.i_cfg_we       = t_we;
        bus.i_cfg_sel      = t_sel;
        bus.i_cfg_data     = t_data;
        bus.i_lock         = t_lock;
        bus.i_checkin      = t_ci;
        bus.i_fail_safe    = t_fs;
        bus.i_hardware_rst = t_hr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        q.push_back(snap());
    endtask

    task automatic idle(input int n);
        t_we = 0; t_lock = 0; t_ci = '0; t_fs = 0; t_hr = 0;
        drive();
        repeat (n) tick();
    endtask

    task automatic wr(input logic [1:0] sel, input logic [W-1:0] d, input logic lk);
        t_we = 1; t_sel = sel; t_data = d; t_lock = lk;
        drive(); tick();
        t_we = 0; t_lock = 0; drive();
    endtask

    task automatic ci(input logic [N-1:0] v);
        t_ci = v; drive(); tick();
        t_ci = '0; drive();
    endtask

    task automatic lock_req();
        t_lock = 1; drive(); tick();
        t_lock = 0; drive();
    endtask

    task automatic fsh(input logic fs, input logic hr, input int n);
        t_fs = fs; t_hr = hr; drive();
        repeat (n) tick();
    endtask

    task automatic rnd_cycle();
        t_we   = ($urandom_range(0, 9) == 0);
        t_sel  = 2'($urandom_range(0, 3));
        t_data = $urandom;
        t_lock = ($urandom_range(0, 7) == 0);
        t_ci   = ($urandom_range(0, 2) == 0) ? N'($urandom_range(1, (1 << N) - 1)) : '0;
        if (ep == 0 && $urandom_range(0, 39) == 0) begin
            ep     = $urandom_range(2, 8);
            hr_len = $urandom_range(0, 4);
        end
        t_fs = (ep > 0);
        t_hr = (ep > 0) && (ep <= hr_len);
        if (ep > 0) ep--;
        drive(); tick();
    endtask

    initial begin
        t_rst = 1; t_we = 0; t_sel = '0; t_data = '0; t_lock = 0;
        t_ci = '0; t_fs = 0; t_hr = 0;
        model_reset();
        drive();
        tick(); tick();
        t_rst = 0;
        idle(2);

        // lock with an empty mask is refused
        wr(2'd2, '0, 1'b0);
        lock_req();
        idle(1);

        // configure and arm: wait=20 rst=5 mask=0101 window=3
        wr(2'd0, W'(20), 1'b0);
        wr(2'd1, W'(5), 1'b0);
        wr(2'd2, W'(5), 1'b0);
        wr(2'd3, W'(3), 1'b0);
        lock_req();
        wr(2'd0, W'(99), 1'b0);   // ignored once locked
        ci(4'b0001);              // window count 1: early
        idle(2);
        ci(4'b0001);
        ci(4'b0100);
        idle(5);

        // only task0 present when the timer trips
        ci(4'b0001);
        fsh(1'b1, 1'b0, 2);
        fsh(1'b1, 1'b1, 5);
        fsh(1'b0, 1'b0, 3);

        repeat (400) rnd_cycle();
        ep = 0;
        idle(3);

        // reach HWRST, then pull reset between clock edges
        fsh(1'b1, 1'b0, 1);
        fsh(1'b1, 1'b1, 2);
        #1;
        t_rst = 1; t_fs = 0; t_hr = 0;
        drive();
        q.delete();
        model_reset();
        q.push_back(snap());
        tick(); tick();
        t_rst = 0;
        idle(1);

        // write+lock in one cycle: the new mask decides
        wr(2'd2, '0, 1'b1);
        idle(1);
        wr(2'd2, W'(5), 1'b1);

        // window 0: a check-in during the clear cycle starts the next window
        ci(4'b0101);
        ci(4'b0001);
        ci(4'b0100);
        idle(3);

        repeat (400) rnd_cycle();
        ep = 0;
        idle(2);
        stim_done = 1;
    end

endmodule
